// File: rtl/ami_pkg.sv
// Shared encodings for the AXI write splitter: response codes, burst type,
// page size and FSM state constants.
package ami_pkg;
    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } bresp_e;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam int         AMI_4KB    = 4096;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SPLIT  = 2'd1;
    localparam state_t ST_WAIT_B = 2'd2;
    localparam state_t ST_RESP   = 2'd3;
endpackage

// File: rtl/ami_sfifo.sv
// Small synchronous FIFO holding the AWLEN of every burst whose W beats are
// still owed; the head drives the WLAST comparison.
module ami_sfifo #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = (D > 1) ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);

    logic [W-1:0]  mem_q [D];
    logic [PW-1:0] wp_q, rp_q;
    logic [CW-1:0] cnt_q;
    logic          wr, rd;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == CW'(D));
    assign empty_o = (cnt_q == '0);
    assign dout_o  = mem_q[rp_q];
    assign wr      = push_i & ~full_o;
    assign rd      = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wp_q] <= din_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr) wp_q <= inc(wp_q);
            if (rd) rp_q <= inc(rp_q);
            case ({wr, rd})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/ami_wsplit.sv
// AXI4 write master: splits one long user write into 4KB-safe INCR bursts,
// keeps up to AMI_OD in flight and folds all B responses into one reply.
module ami_wsplit
    import ami_pkg::*;
#(
    parameter int AXI_DW     = 128,
    parameter int AXI_AW     = 32,
    parameter int AXI_IW     = 8,
    parameter int AXI_LW     = 8,
    parameter int USR_LW     = 16,
    parameter int MAX_BL     = 256,
    parameter int AMI_OD     = 4,
    parameter int AXI_WSTRBW = AXI_DW / 8
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    output logic [AXI_IW-1:0]     AWID,
    output logic [AXI_AW-1:0]     AWADDR,
    output logic [AXI_LW-1:0]     AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [AXI_DW-1:0]     WDATA,
    output logic [AXI_WSTRBW-1:0] WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [AXI_IW-1:0]     BID,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    input  logic [AXI_IW-1:0]     usr_awid,
    input  logic [AXI_AW-1:0]     usr_awaddr,
    input  logic [USR_LW-1:0]     usr_awlen,
    input  logic                  usr_awvalid,
    output logic                  usr_awready,
    input  logic [AXI_DW-1:0]     usr_wdata,
    input  logic [AXI_WSTRBW-1:0] usr_wstrb,
    input  logic                  usr_wvalid,
    output logic                  usr_wready,
    output logic [AXI_IW-1:0]     usr_bid,
    output logic [1:0]            usr_bresp,
    output logic                  usr_bvalid,
    input  logic                  usr_bready
);
    localparam int ASZ = $clog2(AXI_WSTRBW);
    localparam int RW  = USR_LW + 1;
    localparam int CW  = (RW > 13) ? RW : 13;
    localparam int OW  = $clog2(AMI_OD + 1);

    state_t            state_q, state_d;
    logic [AXI_IW-1:0] id_q;
    logic [AXI_AW-1:0] addr_q, awaddr_q, cur_addr;
    logic [RW-1:0]     rem_q, cur_rem;
    logic [AXI_LW-1:0] awlen_q, wcnt_q, fifo_head;
    logic [OW-1:0]     outst_q, outst_d;
    logic [1:0]        err_q;
    logic              awv_q, awrdy_q;
    logic [CW-1:0]     pg_beats, beats;
    logic              cmd_hs, aw_hs, w_hs, b_hs, slot_free, load;
    logic              fifo_full, fifo_empty;

    assign cmd_hs    = usr_awvalid & awrdy_q;
    assign aw_hs     = awv_q & AWREADY;
    assign w_hs      = WVALID & WREADY;
    assign b_hs      = BVALID & BREADY;
    assign outst_d   = outst_q + OW'(aw_hs) - OW'(b_hs);
    assign slot_free = ~awv_q | aw_hs;
    // A fresh burst may replace the one being accepted this cycle, so AWVALID
    // stays high back-to-back as long as the outstanding budget allows.
    assign load = cmd_hs | ((state_q == ST_SPLIT) & (rem_q != '0) & slot_free &
                            (outst_d < OW'(AMI_OD)) & ~fifo_full);

    // In IDLE the first burst is cut straight from the command inputs.
    always_comb begin
        cur_addr = addr_q;
        cur_rem  = rem_q;
        if (state_q == ST_IDLE) begin
            cur_addr = usr_awaddr & ~AXI_AW'(AXI_WSTRBW - 1);
            cur_rem  = RW'(usr_awlen) + RW'(1);
        end
        pg_beats = CW'((13'(AMI_4KB) - {1'b0, cur_addr[11:0]}) >> ASZ);
        beats    = CW'(cur_rem);
        if (beats > CW'(MAX_BL)) beats = CW'(MAX_BL);
        if (beats > pg_beats)    beats = pg_beats;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cmd_hs) state_d = ST_SPLIT;
            ST_SPLIT:  if ((rem_q == '0) && slot_free) state_d = ST_WAIT_B;
            ST_WAIT_B: if ((outst_q == '0) && fifo_empty) state_d = ST_RESP;
            default:   if (usr_bready) state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q  <= ST_IDLE;
            id_q     <= '0;
            addr_q   <= '0;
            rem_q    <= '0;
            awv_q    <= 1'b0;
            awaddr_q <= '0;
            awlen_q  <= '0;
            outst_q  <= '0;
            err_q    <= RESP_OKAY;
            awrdy_q  <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            state_q <= state_d;
            awrdy_q <= (state_d == ST_IDLE);
            outst_q <= outst_d;
            if (cmd_hs) id_q <= usr_awid;
            if (load) begin
                awv_q    <= 1'b1;
                awaddr_q <= cur_addr;
                awlen_q  <= AXI_LW'(beats - 1'b1);
                addr_q   <= cur_addr + (AXI_AW'(beats) << ASZ);
                rem_q    <= cur_rem - RW'(beats);
            end else if (aw_hs) begin
                awv_q <= 1'b0;
            end
            if (w_hs) wcnt_q <= WLAST ? '0 : wcnt_q + 1'b1;
            // First error wins; a foreign BID counts as SLVERR.
            if (cmd_hs) begin
                err_q <= RESP_OKAY;
            end else if (b_hs && err_q == RESP_OKAY) begin
                if (BRESP == RESP_SLVERR || BRESP == RESP_DECERR) err_q <= BRESP;
                else if (BID != id_q)                             err_q <= RESP_SLVERR;
            end
        end
    end

    ami_sfifo #(.W(AXI_LW), .D(AMI_OD)) u_lfifo (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .push_i  (aw_hs),
        .pop_i   (w_hs & WLAST),
        .din_i   (awlen_q),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign AWID        = id_q;
    assign AWADDR      = awaddr_q;
    assign AWLEN       = awlen_q;
    assign AWSIZE      = 3'(ASZ);
    assign AWBURST     = BURST_INCR;
    assign AWVALID     = awv_q;
    assign WDATA       = usr_wdata;
    assign WSTRB       = usr_wstrb;
    assign WVALID      = usr_wvalid & ~fifo_empty;
    assign usr_wready  = WREADY & ~fifo_empty;
    assign WLAST       = ~fifo_empty & (wcnt_q == fifo_head);
    assign BREADY      = ((state_q == ST_SPLIT) || (state_q == ST_WAIT_B)) && (outst_q != '0);
    assign usr_awready = awrdy_q;
    assign usr_bvalid  = (state_q == ST_RESP);
    assign usr_bresp   = err_q;
    assign usr_bid     = id_q;
endmodule

// File: tb/tb_ami_wsplit.sv
// Bench for ami_wsplit: command table with expected bursts, randomized AXI slave,
// scoreboard queues for AW / W / B / user response, plus reset and B-hold sequences.
module tb_ami_wsplit;
    import ami_pkg::*;

    logic         ACLK = 1'b0, ARESET = 1'b1;
    logic [7:0]   AWID, BID, usr_awid, usr_bid;
    logic [31:0]  AWADDR, usr_awaddr;
    logic [7:0]   AWLEN;
    logic [2:0]   AWSIZE;
    logic [1:0]   AWBURST, BRESP, usr_bresp;
    logic         AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic [127:0] WDATA, usr_wdata;
    logic [15:0]  WSTRB, usr_wstrb, usr_awlen;
    logic         usr_awvalid, usr_awready, usr_wvalid, usr_wready, usr_bvalid, usr_bready;

    always #5 ACLK = ~ACLK;

    ami_wsplit #(.AXI_DW(128), .AXI_AW(32), .AXI_IW(8), .AXI_LW(8), .USR_LW(16),
                 .MAX_BL(256), .AMI_OD(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .usr_awid(usr_awid), .usr_awaddr(usr_awaddr), .usr_awlen(usr_awlen),
        .usr_awvalid(usr_awvalid), .usr_awready(usr_awready), .usr_wdata(usr_wdata),
        .usr_wstrb(usr_wstrb), .usr_wvalid(usr_wvalid), .usr_wready(usr_wready),
        .usr_bid(usr_bid), .usr_bresp(usr_bresp), .usr_bvalid(usr_bvalid),
        .usr_bready(usr_bready)
    );

    typedef struct packed {
        logic [31:0] addr; logic [15:0] len; logic badbid; logic holdb; logic [1:0] exp;
    } vec_t;
    typedef struct packed {
        int vi; logic [31:0] a; logic [7:0] l; logic [1:0] r;
    } btab_t;
    typedef struct packed {
        logic [31:0] a; logic [7:0] l; logic [1:0] r; logic [7:0] id; logic bad;
    } aw_t;

    vec_t       vt[$];
    btab_t      bt[$];
    aw_t        aw_exp[$], b_pend[$];
    logic [7:0] wl_q[$], id_exp[$];
    logic [1:0] r_exp[$];
    int nchk = 0, nerr = 0;
    int awcnt = 0, bcnt = 0, wdone = 0, wb = 0, wleft = 0, wseq = 0, aw_base = 0;
    bit hold_b = 0, flush = 1, b_acc = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        nchk++; nerr++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    task automatic addv(input logic [31:0] a, input logic [15:0] l, input logic bad,
                        input logic hb, input logic [1:0] ex);
        vec_t v;
        v.addr = a; v.len = l; v.badbid = bad; v.holdb = hb; v.exp = ex;
        vt.push_back(v);
    endtask

    task automatic addb(input int vi, input logic [31:0] a, input logic [7:0] l, input logic [1:0] r);
        btab_t b;
        b.vi = vi; b.a = a; b.l = l; b.r = r;
        bt.push_back(b);
    endtask

    // AW slave: random AWREADY, every accepted burst checked against the scoreboard.
    initial forever begin
        aw_t e;
        @(negedge ACLK);
        AWREADY = ($urandom_range(0, 3) != 0);
        #1;
        if (!flush && AWVALID && AWREADY) begin
            awcnt++;
            if (aw_exp.size() == 0) chk("aw_unexpected", 1, 0);
            else begin
                e = aw_exp.pop_front();
                chk("awaddr", AWADDR, e.a);
                chk("awlen", AWLEN, e.l);
                chk("awid", AWID, e.id);
                chk("awsize", AWSIZE, 3'd4);
                chk("awburst", AWBURST, 2'b01);
                wl_q.push_back(e.l);
                b_pend.push_back(e);
            end
        end
    end

    // User data source and W slave; WLAST expected from the accepted AWLEN queue.
    initial forever begin
        @(negedge ACLK);
        usr_wvalid = (wleft > 0) && ($urandom_range(0, 3) != 0);
        usr_wdata  = {4{wseq}};
        usr_wstrb  = wseq[15:0] ^ 16'hA5C3;
        WREADY     = ($urandom_range(0, 4) != 0);
        #1;
        if (!flush && WVALID && WREADY) begin
            chk("wdata", WDATA, {4{wseq}});
            chk("wstrb", WSTRB, wseq[15:0] ^ 16'hA5C3);
            if (wl_q.size() == 0) chk("w_before_aw", 1, 0);
            else begin
                chk("wlast", WLAST, (wb == int'(wl_q[0])));
                if (wb == int'(wl_q[0])) begin
                    void'(wl_q.pop_front());
                    wb = 0;
                    wdone++;
                end else wb++;
            end
            wseq++;
            wleft--;
        end
    end

    // B slave: answers only bursts whose data has completed, unless held.
    initial forever begin
        @(negedge ACLK);
        if (flush || b_acc) begin BVALID = 1'b0; b_acc = 0; end
        if (!flush && !BVALID && !hold_b && bcnt < wdone && b_pend.size() > 0 &&
            $urandom_range(0, 2) != 0) begin
            BVALID = 1'b1;
            BID    = b_pend[0].id ^ {7'd0, b_pend[0].bad};
            BRESP  = b_pend[0].r;
        end
        #1;
        if (!flush && BVALID && BREADY) begin
            b_acc = 1;
            void'(b_pend.pop_front());
            bcnt++;
        end
    end

    task automatic send_cmd(input int i);
        aw_t e;
        int n, c, t;
        n = 0; c = 0;
        foreach (bt[k]) if (bt[k].vi == i) n++;
        foreach (bt[k]) if (bt[k].vi == i) begin
            c++;
            e.a = bt[k].a; e.l = bt[k].l; e.r = bt[k].r;
            e.id = 8'(32'h20 + i);
            e.bad = vt[i].badbid && (c == n);
            aw_exp.push_back(e);
        end
        r_exp.push_back(vt[i].exp);
        id_exp.push_back(8'(32'h20 + i));
        hold_b  = vt[i].holdb;
        aw_base = awcnt;
        @(negedge ACLK);
        usr_awvalid = 1'b1; usr_awaddr = vt[i].addr; usr_awlen = vt[i].len;
        usr_awid = 8'(32'h20 + i);
        #1;
        t = 0;
        while (!usr_awready && t < 500) begin @(negedge ACLK); #1; t++; end
        if (!usr_awready) tmo("cmd_accept");
        wleft += int'(vt[i].len) + 1;
        @(negedge ACLK);
        usr_awvalid = 1'b0;
        #1;
        chk("awvalid_latency", AWVALID, 1);
    endtask

    task automatic finish_vec();
        int t;
        bit got;
        t = 0; got = 0;
        while (t < 20000 && !got) begin
            @(negedge ACLK);
            usr_bready = ($urandom_range(0, 1) != 0);
            #1;
            if (usr_bvalid && usr_bready) got = 1;
            t++;
        end
        if (!got) tmo("usr_bvalid");
        else if (r_exp.size() == 0) chk("resp_unexpected", 1, 0);
        else begin
            chk("usr_bresp", usr_bresp, r_exp.pop_front());
            chk("usr_bid", usr_bid, id_exp.pop_front());
        end
        @(negedge ACLK);
        usr_bready = 1'b0;
        #1;
        chk("single_usr_bvalid", usr_bvalid, 0);
        chk("all_aw_issued", aw_exp.size(), 0);
        chk("all_b_returned", b_pend.size(), 0);
    endtask

    // Four bursts in flight with B withheld: the 5th AW must wait for the first B.
    task automatic holdb_seq();
        int t, b0;
        t = 0;
        while (wdone - aw_base < 4 && t < 20000) begin @(negedge ACLK); #2; t++; end
        if (t >= 20000) tmo("holdb_wdata");
        repeat (5) @(negedge ACLK);
        #2;
        chk("awvalid_held_at_limit", AWVALID, 0);
        chk("aw_count_at_limit", awcnt - aw_base, 4);
        b0 = bcnt; hold_b = 0; t = 0;
        while (bcnt == b0 && t < 200) begin @(negedge ACLK); #2; t++; end
        if (bcnt == b0) tmo("holdb_first_b");
        chk("awvalid_before_first_b", AWVALID, 0);
        @(negedge ACLK);
        #2;
        chk("awvalid_after_first_b", AWVALID, 1);
    endtask

    task automatic reset_seq();
        int t, d0;
        d0 = wdone;
        send_cmd(2);
        t = 0;
        while (!(wdone - d0 >= 1 && wb >= 4) && t < 20000) begin @(negedge ACLK); #2; t++; end
        if (t >= 20000) tmo("reset_burst2");
        @(negedge ACLK);
        ARESET = 1'b1; flush = 1;
        @(negedge ACLK);
        #1;
        chk("rst_mid_awvalid", AWVALID, 0);
        chk("rst_mid_wvalid", WVALID, 0);
        chk("rst_mid_usr_bvalid", usr_bvalid, 0);
        aw_exp.delete(); b_pend.delete(); wl_q.delete(); r_exp.delete(); id_exp.delete();
        wleft = 0; wb = 0; wdone = 0; bcnt = 0; hold_b = 0;
        @(negedge ACLK);
        ARESET = 1'b0;
        #2;
        flush = 0;
        @(negedge ACLK);
        #1;
        chk("awready_after_release", usr_awready, 1);
    endtask

    initial begin
        usr_awvalid = 0; usr_awaddr = 0; usr_awlen = 0; usr_awid = 0; usr_bready = 0;
        usr_wvalid = 0; usr_wdata = 0; usr_wstrb = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BID = 0; BRESP = 0;

        addv(32'h1000, 15, 0, 0, 2'b00);  addb(0, 32'h1000, 15, 2'b00);
        addv(32'h0F80, 31, 0, 0, 2'b00);  addb(1, 32'h0F80, 7, 2'b00);  addb(1, 32'h1000, 23, 2'b00);
        addv(32'h0, 599, 0, 0, 2'b00);
        addb(2, 32'h0, 255, 2'b00); addb(2, 32'h1000, 255, 2'b00); addb(2, 32'h2000, 87, 2'b00);
        addv(32'h0, 1535, 0, 1, 2'b00);
        for (int k = 0; k < 6; k++) addb(3, 32'(k * 4096), 255, 2'b00);
        addv(32'h0, 599, 0, 0, 2'b10);
        addb(4, 32'h0, 255, 2'b00); addb(4, 32'h1000, 255, 2'b10); addb(4, 32'h2000, 87, 2'b11);
        addv(32'h0F80, 31, 1, 0, 2'b10);  addb(5, 32'h0F80, 7, 2'b00);  addb(5, 32'h1000, 23, 2'b00);
        addv(32'h2008, 3, 0, 0, 2'b00);   addb(6, 32'h2000, 3, 2'b01);
        addv(32'hFFF0, 1, 0, 0, 2'b11);   addb(7, 32'hFFF0, 0, 2'b11); addb(7, 32'h10000, 0, 2'b10);

        repeat (3) @(negedge ACLK);
        #1;
        chk("rst_awvalid", AWVALID, 0);
        chk("rst_awaddr", AWADDR, 0);
        chk("rst_awlen", AWLEN, 0);
        chk("rst_awid", AWID, 0);
        chk("rst_wvalid", WVALID, 0);
        chk("rst_bready", BREADY, 0);
        chk("rst_usr_awready", usr_awready, 0);
        chk("rst_usr_bvalid", usr_bvalid, 0);
        chk("rst_usr_bresp", usr_bresp, 0);
        chk("rst_usr_bid", usr_bid, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        #2;
        flush = 0;
        @(negedge ACLK);
        #1;
        chk("awready_after_reset", usr_awready, 1);

        for (int i = 0; i < vt.size(); i++) begin
            send_cmd(i);
            if (vt[i].holdb) holdb_seq();
            finish_vec();
        end

        reset_seq();
        send_cmd(0);
        finish_vec();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
